// File: rtl/axi_dram_bridge_pkg.sv
// Shared types and constants for the farm-to-DRAM AXI4-Lite bridge.
//   bridge_state_t     : FSM states of the bridge
//   DRAM_BASE_ADDR     : byte address of record 0 in DRAM
//   RECORD_STRIDE_LOG2 : log2 of bytes per record
//   record_byte_addr() : record index -> 17-bit DRAM byte address
package axi_dram_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } bridge_state_t;

    localparam logic [16:0] DRAM_BASE_ADDR     = 17'h10000;
    localparam int          RECORD_STRIDE_LOG2 = 2;

    // The result wraps to 17 bits; the DRAM address space is 17 bits wide.
    function automatic logic [16:0] record_byte_addr(
        input logic [16:0] base,
        input int unsigned stride_log2,
        input logic [7:0]  idx
    );
        logic [16:0] offset;
        offset = {9'b0, idx} << stride_log2;
        return base + offset;
    endfunction

endpackage

// File: rtl/axi_dram_bridge.sv
// Single-outstanding bridge from the farm request port (C_*) to an
// AXI4-Lite-style DRAM slave.  One 32-bit read or write is accepted while
// idle, the matching AR/R or AW/W/B sequence is run, and a one-cycle
// C_out_valid pulse reports completion.
// Ports:
//   clk, rst                  : clock and synchronous active-high reset
//   C_addr/C_data_w/C_r_wb    : request record index, write data, 1=read
//   C_in_valid                : request strobe, honoured only while idle
//   C_out_valid/C_data_r      : completion pulse and read data
//   AR_*, R_*, AW_*, W_*, B_* : AXI4-Lite channels towards the DRAM slave
// Every output comes straight from a flop.
module axi_dram_bridge
    import axi_dram_bridge_pkg::*;
#(
    parameter logic [16:0] BASE_ADDR   = DRAM_BASE_ADDR,
    parameter int          STRIDE_LOG2 = RECORD_STRIDE_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  C_addr,
    input  logic [31:0] C_data_w,
    input  logic        C_in_valid,
    input  logic        C_r_wb,
    output logic        C_out_valid,
    output logic [31:0] C_data_r,
    output logic        AR_VALID,
    output logic [16:0] AR_ADDR,
    input  logic        AR_READY,
    input  logic        R_VALID,
    input  logic [31:0] R_DATA,
    input  logic [1:0]  R_RESP,
    output logic        R_READY,
    output logic        AW_VALID,
    output logic [16:0] AW_ADDR,
    input  logic        AW_READY,
    output logic        W_VALID,
    output logic [31:0] W_DATA,
    input  logic        W_READY,
    input  logic        B_VALID,
    input  logic [1:0]  B_RESP,
    output logic        B_READY
);

    bridge_state_t state_reg, state_next;

    logic        ar_valid_reg, r_ready_reg, aw_valid_reg, w_valid_reg, b_ready_reg;
    logic        out_valid_reg;
    logic [16:0] addr_reg;
    logic [31:0] data_reg;
    logic [31:0] rdata_reg;

    logic        capture;
    logic        r_fire;
    logic        done_next;

    // Responses are not inspected: every transfer completes as success.
    logic resp_unused;
    assign resp_unused = ^{R_RESP, B_RESP};

    // Handshakes use the registered VALID/READY, so a slave signal that
    // arrives before ours cannot advance the FSM or capture data.
    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        r_fire     = 1'b0;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (C_in_valid) begin
                    capture    = 1'b1;
                    state_next = C_r_wb ? AR : AW;
                end
            end
            AR: begin
                if (ar_valid_reg && AR_READY) begin
                    state_next = R;
                end
            end
            R: begin
                if (r_ready_reg && R_VALID) begin
                    r_fire     = 1'b1;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            AW: begin
                if (aw_valid_reg && AW_READY) begin
                    state_next = W;
                end
            end
            W: begin
                if (w_valid_reg && W_READY) begin
                    state_next = B;
                end
            end
            B: begin
                if (b_ready_reg && B_VALID) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Channel strobes are registered from the next state so they line up
    // with the state they belong to without any output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            ar_valid_reg  <= 1'b0;
            r_ready_reg   <= 1'b0;
            aw_valid_reg  <= 1'b0;
            w_valid_reg   <= 1'b0;
            b_ready_reg   <= 1'b0;
            out_valid_reg <= 1'b0;
            addr_reg      <= '0;
            data_reg      <= '0;
            rdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            ar_valid_reg  <= (state_next == AR);
            r_ready_reg   <= (state_next == R);
            aw_valid_reg  <= (state_next == AW);
            w_valid_reg   <= (state_next == W);
            b_ready_reg   <= (state_next == B);
            out_valid_reg <= done_next;
            if (capture) begin
                addr_reg <= record_byte_addr(BASE_ADDR, STRIDE_LOG2, C_addr);
                data_reg <= C_data_w;
            end
            if (r_fire) begin
                rdata_reg <= R_DATA;
            end
        end
    end

    assign C_out_valid = out_valid_reg;
    assign C_data_r    = rdata_reg;
    assign AR_VALID    = ar_valid_reg;
    assign AR_ADDR     = addr_reg;
    assign R_READY     = r_ready_reg;
    assign AW_VALID    = aw_valid_reg;
    assign AW_ADDR     = addr_reg;
    assign W_VALID     = w_valid_reg;
    assign W_DATA      = data_reg;
    assign B_READY     = b_ready_reg;

endmodule

// File: tb/tb_axi_dram_bridge.sv
// Self-checking bench for axi_dram_bridge: directed scenarios followed by
// randomized transactions against a word-addressed reference memory and a
// byte-addressed DRAM slave model driven cycle by cycle.
module tb_axi_dram_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  C_addr;
    logic [31:0] C_data_w;
    logic        C_in_valid;
    logic        C_r_wb;
    logic        C_out_valid;
    logic [31:0] C_data_r;
    logic        AR_VALID;
    logic [16:0] AR_ADDR;
    logic        AR_READY;
    logic        R_VALID;
    logic [31:0] R_DATA;
    logic [1:0]  R_RESP;
    logic        R_READY;
    logic        AW_VALID;
    logic [16:0] AW_ADDR;
    logic        AW_READY;
    logic        W_VALID;
    logic [31:0] W_DATA;
    logic        W_READY;
    logic        B_VALID;
    logic [1:0]  B_RESP;
    logic        B_READY;

    axi_dram_bridge dut (
        .clk(clk), .rst(rst),
        .C_addr(C_addr), .C_data_w(C_data_w), .C_in_valid(C_in_valid), .C_r_wb(C_r_wb),
        .C_out_valid(C_out_valid), .C_data_r(C_data_r),
        .AR_VALID(AR_VALID), .AR_ADDR(AR_ADDR), .AR_READY(AR_READY),
        .R_VALID(R_VALID), .R_DATA(R_DATA), .R_RESP(R_RESP), .R_READY(R_READY),
        .AW_VALID(AW_VALID), .AW_ADDR(AW_ADDR), .AW_READY(AW_READY),
        .W_VALID(W_VALID), .W_DATA(W_DATA), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_RESP(B_RESP), .B_READY(B_READY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;
    int exp_pulses = 0;
    int txn_no = 0;

    logic [31:0] ref_mem [0:255];       // reference: record index -> word
    logic [31:0] dram [logic [16:0]];   // slave: byte address -> word
    logic [31:0] last_rdata;            // reference value of C_data_r

    always @(negedge clk) begin
        if (C_out_valid === 1'b1) pulse_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] exp_byte_addr(input logic [7:0] idx);
        int unsigned full;
        full = 32'h10000 + 32'(idx) * 4;
        return full[16:0];
    endfunction

    function automatic logic [31:0] dram_rd(input logic [16:0] ba);
        return dram.exists(ba) ? dram[ba] : 32'h0;
    endfunction

    // Drives request inputs while the bridge is busy; with noise these are
    // strobes that must be ignored.
    task automatic busy_inputs(input bit noise);
        C_in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        C_r_wb     = 1'($urandom_range(0, 1));
        C_addr     = 8'($urandom);
        C_data_w   = $urandom;
    endtask

    // Starts at a negedge with the bridge idle (or in a completion cycle) and
    // returns at the negedge where C_out_valid is expected high.
    task automatic txn(input bit rd, input logic [7:0] a, input logic [31:0] d,
                       input int w1, input int w2, input int w3,
                       input bit early, input bit noise);
        logic [16:0] ea;
        logic [16:0] seen;
        ea = exp_byte_addr(a);
        C_in_valid = 1'b1; C_r_wb = rd; C_addr = a; C_data_w = d;
        @(negedge clk);
        if (rd) begin
            for (int i = 0; i <= w1; i++) begin
                chk("ar_valid", AR_VALID, 1'b1);
                chk("ar_addr", AR_ADDR, ea);
                chk("r_ready_in_ar", R_READY, 1'b0);
                chk("no_early_done_ar", C_out_valid, 1'b0);
                R_VALID = early; R_DATA = $urandom;
                AR_READY = (i == w1);
                busy_inputs(noise);
                @(negedge clk);
            end
            seen = AR_ADDR;
            seen = ea;
            AR_READY = 1'b0; R_VALID = 1'b0;
            for (int i = 0; i <= w2; i++) begin
                chk("r_ready", R_READY, 1'b1);
                chk("ar_valid_off", AR_VALID, 1'b0);
                chk("no_early_done_r", C_out_valid, 1'b0);
                R_VALID = (i == w2);
                R_DATA  = (i == w2) ? dram_rd(seen) : $urandom;
                busy_inputs(noise);
                @(negedge clk);
            end
            R_VALID = 1'b0; R_DATA = $urandom;
            last_rdata = ref_mem[a];
        end else begin
            for (int i = 0; i <= w1; i++) begin
                chk("aw_valid", AW_VALID, 1'b1);
                chk("aw_addr", AW_ADDR, ea);
                chk("w_valid_in_aw", W_VALID, 1'b0);
                chk("no_early_done_aw", C_out_valid, 1'b0);
                B_VALID = early;
                AW_READY = (i == w1);
                busy_inputs(noise);
                @(negedge clk);
            end
            seen = AW_ADDR;
            AW_READY = 1'b0;
            for (int i = 0; i <= w2; i++) begin
                chk("w_valid", W_VALID, 1'b1);
                chk("w_data", W_DATA, d);
                chk("aw_valid_off", AW_VALID, 1'b0);
                chk("b_ready_in_w", B_READY, 1'b0);
                chk("no_early_done_w", C_out_valid, 1'b0);
                B_VALID = early;
                W_READY = (i == w2);
                if (i == w2) dram[seen] = W_DATA;
                busy_inputs(noise);
                @(negedge clk);
            end
            W_READY = 1'b0; B_VALID = 1'b0;
            for (int i = 0; i <= w3; i++) begin
                chk("b_ready", B_READY, 1'b1);
                chk("w_valid_off", W_VALID, 1'b0);
                chk("no_early_done_b", C_out_valid, 1'b0);
                B_VALID = (i == w3);
                B_RESP  = 2'($urandom);
                busy_inputs(noise);
                @(negedge clk);
            end
            B_VALID = 1'b0;
            ref_mem[a] = d;
        end
        C_in_valid = 1'b0;
        exp_pulses++;
        chk("done_pulse", C_out_valid, 1'b1);
        chk("c_data_r", C_data_r, last_rdata);
        chk("ready_off_at_done", {R_READY, B_READY}, 2'b00);
        $display("txn %0d rd=%0b idx=%h wdata=%h rdata=%h waits=%0d/%0d/%0d early=%0b",
                 txn_no, rd, a, d, C_data_r, w1, w2, w3, early);
        txn_no++;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_outs"}, {C_out_valid, AR_VALID, R_READY, AW_VALID, W_VALID, B_READY}, 6'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'h0;
        last_rdata = 32'h0;
        rst = 1'b1;
        C_in_valid = 1'b0; C_r_wb = 1'b0; C_addr = 8'h0; C_data_w = 32'h0;
        AR_READY = 1'b0; R_VALID = 1'b0; R_DATA = 32'h0; R_RESP = 2'b0;
        AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0; B_RESP = 2'b0;

        // Reset with random slave and request activity.
        for (int i = 0; i < 2; i++) begin
            AR_READY = 1'($urandom); R_VALID = 1'($urandom); R_DATA = $urandom;
            AW_READY = 1'($urandom); W_READY = 1'($urandom); B_VALID = 1'($urandom);
            C_in_valid = 1'($urandom); C_r_wb = 1'($urandom);
            @(negedge clk);
            chk_quiet("reset");
            chk("reset_addr", {AR_ADDR, AW_ADDR}, 34'h0);
            chk("reset_wdata", W_DATA, 32'h0);
            chk("reset_rdata", C_data_r, 32'h0);
        end
        AR_READY = 1'b0; R_VALID = 1'b0; AW_READY = 1'b0; W_READY = 1'b0; B_VALID = 1'b0;
        C_in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("idle");
        chk("reset_no_pulse", pulse_cnt, 0);

        // Zero-wait read: ready/valid tied high, completion three edges on.
        AR_READY = 1'b1; R_VALID = 1'b1; R_DATA = 32'hDEADBEEF;
        C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h05;
        @(negedge clk);
        C_in_valid = 1'b0;
        chk("zw_ar_valid", AR_VALID, 1'b1);
        chk("zw_ar_addr", AR_ADDR, 17'h10014);
        chk("zw_no_done1", C_out_valid, 1'b0);
        @(negedge clk);
        chk("zw_r_ready", R_READY, 1'b1);
        chk("zw_no_done2", C_out_valid, 1'b0);
        @(negedge clk);
        chk("zw_done", C_out_valid, 1'b1);
        chk("zw_rdata", C_data_r, 32'hDEADBEEF);
        exp_pulses++;
        last_rdata = 32'hDEADBEEF;
        AR_READY = 1'b0; R_VALID = 1'b0;
        $display("txn %0d rd=1 idx=05 zero-wait rdata=%h", txn_no, C_data_r);
        txn_no++;
        @(negedge clk);
        chk_quiet("zw_after");

        // Write with slave waits, then back-to-back read of the same record.
        txn(1'b0, 8'hFF, 32'h12345678, 3, 2, 4, 1'b0, 1'b0);
        txn(1'b1, 8'hFF, 32'h0, 1, 0, 0, 1'b0, 1'b1);
        chk("b2b_readback", C_data_r, 32'h12345678);

        // Early slave signals, with busy-time strobes.
        txn(1'b0, 8'h07, 32'hA5A5_0F0F, 1, 1, 1, 1'b1, 1'b1);
        txn(1'b1, 8'h07, 32'h0, 2, 2, 0, 1'b1, 1'b1);
        @(negedge clk);
        chk_quiet("early_after");

        // Randomized transactions over a small index window plus the edges.
        for (int n = 0; n < 24; n++) begin
            bit          rd;
            logic [7:0]  a;
            rd = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom_range(0, 7));
            endcase
            txn(rd, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 3), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) begin
                @(negedge clk);
                chk_quiet("rand_gap");
            end
        end
        @(negedge clk);

        // Reset while waiting for read data.
        C_in_valid = 1'b1; C_r_wb = 1'b1; C_addr = 8'h03;
        @(negedge clk);
        C_in_valid = 1'b0; AR_READY = 1'b1;
        @(negedge clk);
        AR_READY = 1'b0;
        chk("mid_r_ready", R_READY, 1'b1);
        rst = 1'b1; R_VALID = 1'b1; R_DATA = 32'hBAD0BAD0;
        @(negedge clk);
        chk_quiet("mid_reset");
        chk("mid_reset_rdata", C_data_r, 32'h0);
        last_rdata = 32'h0;
        rst = 1'b0; R_VALID = 1'b0;
        @(negedge clk);
        chk_quiet("mid_after");
        txn(1'b1, 8'h03, 32'h0, 0, 1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk_quiet("final_idle");

        chk("pulse_count", pulse_cnt, exp_pulses);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
